// File: rtl/simon_multi_core.sv
// simon_multi_core: Simon memory game with LFSR step generator, LED/tone playback and echo checking
module simon_multi_core #(
  parameter int NUM_BTN = 4,
  parameter int MAX_LEN = 32,
  parameter int CLK_KHZ = 10000,
  parameter int TONE_MS = 300,
  parameter int TIMEOUT_MS = 3000
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] led,
  output logic               sound,
  output logic [6:0]         score,
  output logic               game_over,
  output logic               win
);
  localparam int IW = $clog2(NUM_BTN);
  localparam int PW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int OFF_MS = TONE_MS / 2 > 0 ? TONE_MS / 2 : 1;
  localparam logic [3:0] ERR_TONE = 4'hF;
  typedef enum logic [2:0] {IDLE, PLAY_ON, PLAY_OFF, INPUT, ECHO, PAUSE, GAMEOVER, WIN} state_t;
  state_t state, state_n;
  logic [NUM_BTN-1:0] s1, sbtn, exp_oh;
  logic [15:0] lfsr;
  logic [31:0] cyc, ms, half, div;
  logic [IW-1:0] seq [MAX_LEN];
  logic [IW-1:0] new_step, cur, pressed;
  logic [PW-1:0] seq_wa;
  logic [6:0] len, ptr;
  logic [3:0] tone_sel, tone_prev;
  logic armed, prev_any, tick, last, start, grow, done, adv, seq_we, snd_q;
  assign tick = cyc == 32'(CLK_KHZ - 1);
  assign cur = seq[ptr[PW-1:0]];
  assign exp_oh = NUM_BTN'(1) << cur;
  assign last = ptr == len - 7'd1;
  assign new_step = {1'b0, lfsr[IW-1:0]} < (IW+1)'(NUM_BTN) ? lfsr[IW-1:0] : lfsr[IW-1:0] - IW'(NUM_BTN);
  assign start = state == IDLE && state_n == PAUSE;
  assign grow = state == ECHO && state_n == PAUSE;
  assign done = state == ECHO && sbtn == '0 && last;
  assign adv = (state == PLAY_OFF && state_n != PLAY_OFF) || (state == ECHO && sbtn == '0);
  assign seq_we = start || grow;
  assign seq_wa = start ? '0 : len[PW-1:0];
  always_comb begin
    pressed = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) if (sbtn[i]) pressed = IW'(i);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (armed && sbtn == '0) state_n = PAUSE;
      PAUSE:    if (tick && ms == 32'd499) state_n = PLAY_ON;
      PLAY_ON:  if (tick && ms == 32'(TONE_MS - 1)) state_n = PLAY_OFF;
      PLAY_OFF: if (tick && ms == 32'(OFF_MS - 1)) state_n = last ? INPUT : PLAY_ON;
      INPUT:    state_n = sbtn == exp_oh ? ECHO :
                          (sbtn != '0 || (tick && ms == 32'(TIMEOUT_MS - 1))) ? GAMEOVER : INPUT;
      ECHO:     state_n = sbtn == '0 ? (last ? (len == 7'(MAX_LEN) ? WIN : PAUSE) : INPUT) :
                          sbtn != exp_oh ? GAMEOVER : ECHO;
      default:  if (tick && ms == 32'd999) state_n = IDLE;
    endcase
  end
  always_comb begin
    led = state == PLAY_ON || state == GAMEOVER ? exp_oh : state == ECHO ? sbtn :
          state == WIN ? '1 : '0;
    tone_sel = state == PLAY_ON ? 4'(cur) + 4'd1 :
               state == ECHO && sbtn != '0 ? 4'(pressed) + 4'd1 :
               state == GAMEOVER ? ERR_TONE : 4'd0;
    half = 32'(4 * CLK_KHZ);
    for (int k = 0; k < NUM_BTN; k++) if (tone_sel == 4'(k + 1)) half = 32'((2 * CLK_KHZ) / (k + 1));
  end
  // the divider output is only trusted once it has seen the current source for a cycle
  assign sound = snd_q && tone_sel != 4'd0 && tone_sel == tone_prev;
  assign game_over = state == GAMEOVER;
  assign win = state == WIN;
  always_ff @(posedge wb_clk_i) if (seq_we) seq[seq_wa] <= new_step;
  always_ff @(posedge wb_clk_i or negedge wb_rst_i)
    if (!wb_rst_i) begin
      state <= IDLE;
      s1 <= '0;
      sbtn <= '0;
      lfsr <= 16'hACE1;
      cyc <= '0;
      ms <= '0;
      len <= '0;
      ptr <= '0;
      score <= '0;
      armed <= 1'b0;
      prev_any <= 1'b0;
      tone_prev <= '0;
      div <= '0;
      snd_q <= 1'b0;
    end else begin
      state <= state_n;
      s1 <= btn;
      sbtn <= s1;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      cyc <= state_n != state || tick ? '0 : cyc + 32'd1;
      ms <= state_n != state ? '0 : tick ? ms + 32'd1 : ms;
      prev_any <= |sbtn;
      armed <= state == IDLE && state_n == IDLE && (armed || (!prev_any && |sbtn));
      len <= start ? 7'd1 : grow ? len + 7'd1 : len;
      score <= start ? '0 : done ? len : score;
      ptr <= start || state == PAUSE ? '0 : adv ? (last ? '0 : ptr + 7'd1) : ptr;
      tone_prev <= tone_sel;
      div <= tone_sel != tone_prev || tone_sel == 4'd0 || div == half - 32'd1 ? '0 : div + 32'd1;
      snd_q <= tone_sel != tone_prev || tone_sel == 4'd0 ? 1'b0 : div == half - 32'd1 ? ~snd_q : snd_q;
    end
endmodule

// File: tb/tb_simon_multi_core.sv
// tb_simon_multi_core: scoreboard bench for the Simon core, with a reference LFSR to predict each step
module tb_simon_multi_core;
  localparam int NB = 3, ML = 2, CK = 10, TM = 4, TO = 20;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NB-1:0] btn = '0, led;
  logic sound, game_over, win;
  logic [6:0] score;
  logic [15:0] m;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [NB-1:0] exp_q [$];
  simon_multi_core #(.NUM_BTN(NB), .MAX_LEN(ML), .CLK_KHZ(CK), .TONE_MS(TM), .TIMEOUT_MS(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .btn(btn), .led(led), .sound(sound),
    .score(score), .game_over(game_over), .win(win));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) m <= !rst_n ? 16'hACE1 : {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [NB-1:0] oh(input int s);
    return NB'(1) << s;
  endfunction
  function automatic int step_of(input logic [15:0] v);
    int r;
    r = int'(v[1:0]);
    return r < NB ? r : r - NB;
  endfunction
  task automatic release_sample(output int s);
    @(negedge clk);
    btn = '0;
    repeat (2) @(posedge clk);
    #1 s = step_of(m);
  endtask
  task automatic start_game(output int s0);
    @(negedge clk);
    btn = oh(0);
    repeat (5) @(negedge clk);
    release_sample(s0);
    exp_q.push_back(oh(s0));
  endtask
  task automatic play_step(output int gap);
    int on;
    gap = 0;
    while (led == '0 && gap < 6000) begin @(negedge clk); gap++; end
    if (exp_q.size() == 0) chk("sb_empty", 0, 1);
    else chk("play_led", int'(led), int'(exp_q.pop_front()));
    on = 0;
    while (led != '0 && on < 100) begin @(negedge clk); on++; end
    chk("play_on_cycles", on, CK * TM);
  endtask
  task automatic tone_period(output int p);
    int t;
    logic prev;
    t = 0;
    do begin prev = sound; @(negedge clk); t++; end while (!(sound && !prev) && t < 300);
    p = 0;
    do begin prev = sound; @(negedge clk); p++; end while (!(sound && !prev) && p < 300);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while ((game_over || win) && n < 12000) begin @(negedge clk); n++; end
    chk("back_to_idle", int'(game_over || win), 0);
  endtask
  initial begin
    int s0, s1, g, t0, p;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    chk("idle_led", int'(led), 0);
    chk("idle_sound", int'(sound), 0);
    chk("idle_score", int'(score), 0);
    chk("idle_flags", int'({game_over, win}), 0);
    start_game(s0);
    play_step(g);
    chk("pause_cycles", g, 500 * CK + 2);
    repeat (25) @(negedge clk);
    btn = oh(s0);
    tone_period(p);
    chk("echo_tone_period", p, 2 * ((2 * CK) / (s0 + 1)));
    release_sample(s1);
    exp_q.push_back(oh(s0));
    exp_q.push_back(oh(s1));
    repeat (2) @(negedge clk);
    chk("score_round1", int'(score), 1);
    play_step(g);
    play_step(g);
    chk("play_gap_cycles", g, CK * TM / 2);
    repeat (25) @(negedge clk);
    btn = oh(s0);
    repeat (10) @(negedge clk);
    btn = '0;
    repeat (10) @(negedge clk);
    btn = oh(s1);
    repeat (10) @(negedge clk);
    btn = '0;
    repeat (3) @(negedge clk);
    chk("win_flag", int'(win), 1);
    chk("win_led", int'(led), 7);
    chk("win_score", int'(score), ML);
    chk("win_sound", int'(sound), 0);
    t0 = cyc;
    wait_idle();
    chk("win_cycles", cyc - t0, 1000 * CK);
    chk("idle_led_after_win", int'(led), 0);
    chk("score_held", int'(score), ML);
    start_game(s0);
    play_step(g);
    repeat (25) @(negedge clk);
    btn = oh((s0 + 1) % NB);
    repeat (3) @(posedge clk);
    #1;
    chk("wrong_game_over", int'(game_over), 1);
    chk("wrong_led", int'(led), int'(oh(s0)));
    chk("wrong_score", int'(score), 0);
    t0 = cyc;
    tone_period(p);
    chk("error_tone_period", p, 8 * CK);
    btn = '0;
    wait_idle();
    chk("gameover_cycles", cyc - t0, 1000 * CK);
    chk("score_after_gameover", int'(score), 0);
    start_game(s0);
    play_step(g);
    t0 = cyc;
    while (!game_over && cyc - t0 < 400) @(negedge clk);
    chk("timeout_cycles", cyc - t0, CK * TM / 2 + CK * TO);
    chk("timeout_led", int'(led), int'(oh(s0)));
    wait_idle();
    start_game(s0);
    play_step(g);
    repeat (25) @(negedge clk);
    btn = 3'b011;
    repeat (3) @(posedge clk);
    #1;
    chk("multi_game_over", int'(game_over), 1);
    @(negedge clk);
    btn = '0;
    wait_idle();
    start_game(s0);
    g = 0;
    while (led == '0 && g < 6000) begin @(negedge clk); g++; end
    chk("reset_game_led", int'(led), int'(oh(s0)));
    exp_q.delete();
    g = 0;
    while (!sound && g < 40) begin @(negedge clk); g++; end
    chk("sound_before_reset", int'(sound), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_led", int'(led), 0);
    chk("reset_sound", int'(sound), 0);
    #10 rst_n = 1'b1;
    repeat (6000) @(negedge clk);
    chk("post_reset_led", int'(led), 0);
    chk("post_reset_score", int'(score), 0);
    chk("post_reset_flags", int'({game_over, win}), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/simon_multi_core.md
SIMON_MULTI_CORE -- requirements
Module: simon_multi_core

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4, number of buttons/LEDs/tones (2..8).
REQ-002 SHALL have parameter MAX_LEN, default 32, maximum sequence length, i.e. win length (1..64).
REQ-003 SHALL have parameter CLK_KHZ, default 10000, clock cycles per millisecond.
REQ-004 SHALL have parameter TONE_MS, default 300, playback step on-time in ms; gap = TONE_MS/2 ms.
REQ-005 SHALL have parameter TIMEOUT_MS, default 3000, player input timeout in ms.
REQ-006 SHALL have port wb_clk_i  in  1  the single clock.
REQ-007 SHALL have port wb_rst_i  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have port btn  in  NUM_BTN  raw button levels, active-high, asynchronous.
REQ-009 SHALL have port led  out  NUM_BTN  LED drive, active-high.
REQ-010 SHALL have port sound  out  1  square-wave speaker drive.
REQ-011 SHALL have port score  out  7  completed rounds of the current/last game.
REQ-012 SHALL have port game_over  out  1  high while in GAMEOVER.
REQ-013 SHALL have port win  out  1  high while in WIN.

Function
REQ-014 SHALL pass btn through a two-flop synchroniser; all decisions use the synchronised value (sbtn); 2-cycle input latency.
REQ-015 SHALL derive a 1 ms tick from a counter wrapping at CLK_KHZ-1; all durations count ticks, counter restarts on every state entry.
REQ-016 SHALL run a free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reset seed 16'hACE1, advancing every cycle.
REQ-017 SHALL form a new step as r = lfsr[IW-1:0], IW = clog2(NUM_BTN); step = r if r < NUM_BTN else r - NUM_BTN.
REQ-018 SHALL store steps in a MAX_LEN x IW register array; len (current length) and ptr (step index) counters.
REQ-019 SHALL implement states IDLE, PLAY_ON, PLAY_OFF, INPUT, ECHO, PAUSE, GAMEOVER, WIN.
REQ-020 IDLE: led=0, sound=0; on sbtn going from all-zero to nonzero, wait until sbtn all-zero, then store step 0, len=1, ptr=0, score=0, enter PAUSE.
REQ-021 PAUSE: all off for 500 ms, ptr=0, then PLAY_ON.
REQ-022 PLAY_ON: led = onehot(seq[ptr]), tone of seq[ptr] on sound, for TONE_MS ms, then PLAY_OFF.
REQ-023 PLAY_OFF: all off for TONE_MS/2 ms; if ptr == len-1 then ptr=0 and INPUT, else ptr+1 and PLAY_ON.
REQ-024 INPUT: led=0; sbtn exactly onehot(seq[ptr]) -> ECHO; any other nonzero sbtn (wrong or multiple) -> GAMEOVER; TIMEOUT_MS ms without press -> GAMEOVER.
REQ-025 ECHO: led = sbtn, tone of pressed button while held; any extra button during ECHO -> GAMEOVER; on sbtn all-zero: if ptr < len-1 then ptr+1, INPUT.
REQ-026 ECHO release at ptr == len-1: score=len; if len == MAX_LEN -> WIN, else append new step at index len, len+1, PAUSE.
REQ-027 GAMEOVER: led = onehot(seq[ptr]) (expected step), error tone, game_over=1 for 1000 ms, then IDLE; score held.
REQ-028 WIN: led = all ones, sound=0, win=1 for 1000 ms, then IDLE; score = MAX_LEN held.
REQ-029 Tone for button k SHALL toggle sound every (2*CLK_KHZ)/(k+1) cycles (500*(k+1)/2 Hz), constants resolved at elaboration; error tone toggles every 4*CLK_KHZ cycles.
REQ-030 Tone divider SHALL restart at 0 with sound=0 whenever tone source changes or stops; sound=0 whenever no tone is active.
REQ-031 Buttons pressed in PLAY_ON, PLAY_OFF, PAUSE, GAMEOVER, WIN SHALL be ignored.
REQ-032 Timeout and press detected in same cycle: press SHALL win.

Reset
REQ-033 On wb_rst_i low, asynchronously: state=IDLE, led=0, sound=0, score=0, game_over=0, win=0, len=0, ptr=0, lfsr=16'hACE1, all counters 0, sync flops 0.
REQ-034 Reset asserted mid-game SHALL abort immediately; after release the block sits in IDLE with stored steps irrelevant.

Verification (CLK_KHZ=10, NUM_BTN=3, MAX_LEN=2, TONE_MS=4, TIMEOUT_MS=20)
REQ-035 Reset then no input for 1000 cycles -> led=0, sound=0, score=0, state IDLE.
REQ-036 Press/release any button -> after 5000 cycles PAUSE, exactly one led high for 40 cycles, 20 cycles off, sound toggling at that button's period.
REQ-037 Echo every step correctly through 2 rounds -> score=1 after round 1, then win=1, led=3'b111 for 10000 cycles, score=2, then IDLE.
REQ-038 In INPUT press wrong button -> game_over=1 within 3 cycles, led shows expected step, error tone period 80 cycles, 10000 cycles later IDLE, score=0.
REQ-039 In INPUT press nothing for 200 cycles -> game_over=1; press two buttons together -> game_over=1.
REQ-040 Assert wb_rst_i low during PLAY_ON -> led=0 and sound=0 same cycle (async), IDLE after release.
